// File: rtl/debounce_sync.sv
// Switch/button debouncer: two-flop synchronizer followed by a saturating
// stability counter. dout only changes after the synchronized input has
// disagreed with it for STABLE_CYCLES consecutive rising edges. rise/fall
// are registered single-cycle pulses aligned with the dout change.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    // Terminal count: the edge that sees this value with a mismatch commits.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0_q;
    logic             sync1_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             mismatch;

    // Two-flop synchronizer; only sync1_q is used past this point.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= din_i;
            sync1_q <= sync0_q;
        end
    end

    assign mismatch = (sync1_q != dout_q);

    // Next-state: count consecutive mismatches, commit on the terminal count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (mismatch) begin
            // >= keeps the counter from ever running past the terminal count.
            if (cnt_q >= CntLast) begin
                dout_d = sync1_q;
                rise_d = sync1_q;
                fall_d = ~sync1_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state and edge-pulse registers; reset suppresses any pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Outputs: registered level and pulses, combinational busy.
    always_comb begin
        dout_o = dout_q;
        rise_o = rise_q;
        fall_o = fall_q;
        busy_o = (cnt_q != '0);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a STABLE_CYCLES=4 and a STABLE_CYCLES=1 instance
// share stimulus. Fixed vectors, hand sequences for reset/bounce corners,
// then random din/rst against a run-length reference model.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic din_i = 1'b0;
    logic dout4, rise4, fall4, busy4;
    logic dout1, rise1, fall1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3)) u_dut4 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .din_i  (din_i),
        .dout_o (dout4),
        .rise_o (rise4),
        .fall_o (fall4),
        .busy_o (busy4)
    );

    debounce_sync #(.STABLE_CYCLES(1), .CNT_W(1)) u_dut1 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .din_i  (din_i),
        .dout_o (dout1),
        .rise_o (rise1),
        .fall_o (fall1),
        .busy_o (busy1)
    );

    // Reference: din is seen two edges late; dout flips once the delayed
    // input has disagreed with it on `s` consecutive edges.
    typedef struct {
        bit s0;
        bit s1;
        bit dout;
        bit rise;
        bit fall;
        int run;
    } mstate_t;

    mstate_t m4;
    mstate_t m1;

    function automatic mstate_t mstep(input mstate_t m, input bit d, input bit r, input int s);
        mstate_t n;
        n = m;
        if (r) begin
            n.s0 = 0; n.s1 = 0; n.dout = 0; n.rise = 0; n.fall = 0; n.run = 0;
        end else begin
            n.rise = 0;
            n.fall = 0;
            if (m.s1 != m.dout) begin
                n.run = m.run + 1;
                if (n.run == s) begin
                    n.dout = m.s1;
                    n.rise = m.s1;
                    n.fall = !m.s1;
                    n.run  = 0;
                end
            end else begin
                n.run = 0;
            end
            n.s1 = m.s0;
            n.s0 = d;
        end
        return n;
    endfunction

    function automatic int mpack(input mstate_t m);
        return {28'd0, m.dout, m.rise, m.fall, (m.run != 0)};
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // One clock: drive at negedge, model at posedge, compare 1 ns later.
    task automatic tick(input bit d, input bit r);
        din_i = d;
        rst_i = r;
        @(posedge clk);
        m4 = mstep(m4, d, r, 4);
        m1 = mstep(m1, d, r, 1);
        #1;
        check("model_s4", {28'd0, dout4, rise4, fall4, busy4}, mpack(m4));
        check("model_s1", {28'd0, dout1, rise1, fall1, busy1}, mpack(m1));
        @(negedge clk);
    endtask

    function automatic int st4();
        return {28'd0, dout4, rise4, fall4, busy4};
    endfunction

    always @(din_i, dout4, rise4, fall4)
        $display("%0t din=%b dout=%b rise=%b fall=%b", $time, din_i, dout4, rise4, fall4);

    typedef struct {
        bit       rst;
        bit       din;
        bit [3:0] exp4;   // {dout, rise, fall, busy} of the 4-cycle instance
        bit       exp1;   // dout of the 1-cycle instance
    } vec_t;

    vec_t vecs[22];

    initial begin
        int first;
        int cnt;
        int bad;

        m4 = '{0, 0, 0, 0, 0, 0};
        m1 = '{0, 0, 0, 0, 0, 0};

        // Reset with din=1, release, rise at edge 6; then clean fall; then 2-cycle glitch.
        vecs[0]  = '{1, 1, 4'b0000, 0};
        vecs[1]  = '{1, 1, 4'b0000, 0};
        vecs[2]  = '{0, 1, 4'b0000, 0};
        vecs[3]  = '{0, 1, 4'b0000, 0};
        vecs[4]  = '{0, 1, 4'b0001, 1};
        vecs[5]  = '{0, 1, 4'b0001, 1};
        vecs[6]  = '{0, 1, 4'b0001, 1};
        vecs[7]  = '{0, 1, 4'b1100, 1};
        vecs[8]  = '{0, 1, 4'b1000, 1};
        vecs[9]  = '{0, 0, 4'b1000, 1};
        vecs[10] = '{0, 0, 4'b1000, 1};
        vecs[11] = '{0, 0, 4'b1001, 0};
        vecs[12] = '{0, 0, 4'b1001, 0};
        vecs[13] = '{0, 0, 4'b1001, 0};
        vecs[14] = '{0, 0, 4'b0010, 0};
        vecs[15] = '{0, 0, 4'b0000, 0};
        vecs[16] = '{0, 1, 4'b0000, 0};
        vecs[17] = '{0, 1, 4'b0000, 0};
        vecs[18] = '{0, 0, 4'b0001, 1};
        vecs[19] = '{0, 0, 4'b0001, 1};
        vecs[20] = '{0, 0, 4'b0000, 0};
        vecs[21] = '{0, 0, 4'b0000, 0};

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            tick(vecs[i].din, vecs[i].rst);
            check($sformatf("vec%0d_s4", i), st4(), {28'd0, vecs[i].exp4});
            check($sformatf("vec%0d_s1_dout", i), {31'd0, dout1}, {31'd0, vecs[i].exp1});
        end

        // Reset arriving mid-count on a 1->0 step: no fall pulse, dout cleared.
        repeat (8) tick(1, 0);
        check("pre_rst_high", st4(), 4'b1000);
        repeat (4) tick(0, 0);
        check("count_two_busy", st4(), 4'b1001);
        tick(0, 1);
        check("rst_mid_count", st4(), 4'b0000);
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, 0);
            if (fall4) cnt++;
            if (dout4 || busy4) bad++;
        end
        check("rst_no_fall", cnt, 0);
        check("rst_stays_low", bad, 0);

        // Bounce 1,0,1,0 then 1 held: dout rises 6 edges after the last edge.
        for (int k = 0; k < 4; k++) tick((k % 2) == 0, 0);
        first = 0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1, 0);
            if (rise4) cnt++;
            if (dout4 && first == 0) first = k;
        end
        check("bounce_latency", first, 6);
        check("bounce_rises", cnt, 1);

        // Random hold lengths around the threshold with occasional resets.
        for (int i = 0; i < 1500; ) begin
            int  hold;
            bit  d;
            bit  r;
            hold = $urandom_range(1, 7);
            d    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 40) == 0);
            for (int j = 0; j < hold; j++) tick(d, r && (j == 0));
            i += hold;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
